// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic carry_of(input logic g, input logic p, input logic cin);
        return g | (p & cin);
    endfunction

endpackage

// File: rtl/add_32_bit.sv
// 32-bit adder slice with generate/propagate outputs so a sequencer can chain
// words through a registered carry.
module add_32_bit
    import mp_add_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              c_in,
    output logic [WORD_W-1:0] sum,
    output logic              g_out,
    output logic              p_out
);

    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] carry;
    logic              c;
    logic              gg;
    logic              pp;

    // Group generate is the carry out with c_in=0; group propagate is the AND of
    // bit propagates, so the word carry is carry_of(g_out, p_out, c_in).
    // NOTE: every variable written here gets a value before any branch or loop
    // reads it, so no latch can be inferred.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = c_in;
        gg = 1'b0;
        pp = 1'b1;
        carry = '0;
        for (int i = 0; i < WORD_W; i++) begin
            carry[i] = c;
            c        = carry_of(g[i], p[i], c);
            gg       = carry_of(g[i], p[i], gg);
            pp       = pp & p[i];
        end
        sum   = p ^ carry;
        g_out = gg;
        p_out = pp;
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one 32-bit slice, LSW first, carry
// registered between words. Define MP_ADD_OVF_EN to add a signed overflow output.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter  int WORDS = 4,
    localparam int W     = WORD_W * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out
`ifdef MP_ADD_OVF_EN
    ,
    output logic         overflow
`endif
);

    localparam int                IDX_W = $clog2(WORDS) + 1;
    localparam logic [IDX_W-1:0]  LAST  = IDX_W'(WORDS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [W-1:0]      opa_q;
    logic [W-1:0]      opb_q;
    logic              carry_q;
    logic [IDX_W-1:0]  idx_q;

    logic [WORD_W-1:0] slice_a;
    logic [WORD_W-1:0] slice_b;
    logic [WORD_W-1:0] slice_sum;
    logic              slice_g;
    logic              slice_p;
    logic              word_carry;

    assign slice_a    = opa_q[idx_q*WORD_W +: WORD_W];
    assign slice_b    = opb_q[idx_q*WORD_W +: WORD_W];
    assign word_carry = carry_of(slice_g, slice_p, carry_q);

    add_32_bit u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .g_out (slice_g),
        .p_out (slice_p)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        done  = (state_q == DONE);
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and the +1 enters as
    // the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q     <= '0;
            opb_q     <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef MP_ADD_OVF_EN
            overflow  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    opa_q   <= op_a;
                    opb_q   <= sub ? ~op_b : op_b;
                    carry_q <= sub;
                    idx_q   <= '0;
                    result  <= '0;
                end
                RUN: begin
                    result[idx_q*WORD_W +: WORD_W] <= slice_sum;
                    carry_q <= word_carry;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        carry_out <= word_carry;
`ifdef MP_ADD_OVF_EN
                        // Carry into bit 31 recovered from the slice's MSB inputs and sum.
                        overflow  <= (slice_a[WORD_W-1] ^ slice_b[WORD_W-1] ^ slice_sum[WORD_W-1])
                                     ^ word_carry;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
